demux1t16_32_buf: RTL and testbench
===================================

DEMUX1T16_32_BUF -- requirements
Module: demux1t16_32_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of input and of each output channel.
REQ-002 SHALL have parameter NCH, default 16, number of output channels; fixed at 16 in this revision.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port s, input, 4, destination channel select for the current input word.
REQ-006 SHALL have port i, input, WIDTH, input data word.
REQ-007 SHALL have port i_valid, input, 1, upstream offers {s, i}.
REQ-008 SHALL have port i_ready, output, 1, block accepts {s, i} this cycle.
REQ-009 SHALL have port o, output, NCH*WIDTH, packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port o_valid, output, NCH, per-channel data-held flag.
REQ-011 SHALL have port o_ready, input, NCH, per-channel downstream consume.
REQ-012 SHALL have port pending, output, 5, number of channels with o_valid set (0..16).

Function
REQ-013 SHALL drive i_ready = ~o_valid[s] | o_ready[s], combinationally, with no dependence on i_valid.
REQ-014 SHALL define accept = i_valid & i_ready; on accept, channel s data SHALL load i and o_valid[s] SHALL be 1 the next cycle (latency 1).
REQ-015 SHALL clear o_valid[k] on a cycle where o_valid[k] & o_ready[k] and channel k is not being loaded.
REQ-016 SHALL keep o_valid[s] at 1 and load the new word when channel s drains and accepts in the same cycle (no bubble).
REQ-017 SHALL hold channel k data constant while o_valid[k] & ~o_ready[k].
REQ-018 SHALL leave channels other than s unaffected by an accept; their drains proceed independently in the same cycle.
REQ-019 SHALL ignore o_ready[k] while o_valid[k] = 0.
REQ-020 SHALL rely on upstream holding s and i stable while i_valid & ~i_ready; s may change freely when i_valid = 0.
REQ-021 SHALL register pending as the population count of next-state o_valid, so pending always equals popcount(o_valid).
REQ-022 SHALL drive pending = 16 when all channels are full; i_ready is then 1 only if o_ready[s] = 1.
REQ-023 SHALL never drop or duplicate a word: each accept yields exactly one o_valid & o_ready handshake on channel s.

Reset
REQ-024 SHALL on rst = 1 at a clock edge clear o_valid to 0, all channel data to 0, and pending to 0.
REQ-025 SHALL discard held and in-flight words on reset mid-operation; an accept coinciding with rst is lost.
REQ-026 SHALL ignore i_valid and o_ready in the reset cycle; i_ready is 1 from the first cycle after reset.

Structure
REQ-027 SHALL take NCH = 16, SEL_W = 4, and the default WIDTH = 32 from shared package demux_pkg.
REQ-028 SHALL implement each channel as sub-module demux_slot, containing a WIDTH data register and a valid flag with load/drain inputs, instantiated NCH times by generate.
REQ-029 SHALL keep select decode, i_ready mux, and pending counter in the top level.

Verification
REQ-030 SHALL cover this scenario: after reset, s = 3, i = 0xDEADBEEF, i_valid = 1 for one cycle, o_ready = 0 -> next cycle o_valid = 0x0008, o[127:96] = 0xDEADBEEF, pending = 1, all other channels 0.
REQ-031 SHALL cover this scenario: channel 5 full, o_ready[5] = 0, s = 5, i_valid = 1 -> i_ready = 0 and channel 5 holds its old word; raise o_ready[5] -> accept that cycle, new word visible next cycle, o_valid[5] stays 1.
REQ-032 SHALL cover this scenario: fill s = 0..15 with i = 0x100 + k on 16 consecutive cycles, o_ready = 0 -> pending = 16, each channel k holds 0x100 + k; then o_ready = 0xFFFF -> next cycle o_valid = 0, pending = 0.
REQ-033 SHALL cover this scenario: same cycle accept on s = 2 while channel 9 drains -> o_valid[2] sets, o_valid[9] clears, pending unchanged.
REQ-034 SHALL cover this scenario: channels 1 and 7 full, rst = 1 for one cycle with i_valid = 1 and s = 4 -> next cycle o_valid = 0, o = 0, pending = 0, channel 4 not loaded.
REQ-035 SHALL cover this scenario: random s, i_valid, and o_ready for 10k cycles -> scoreboard shows every accepted word emerges exactly once, in order per channel, with data stable while stalled.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-16 buffered demux: channel count, select width,
// default data width, and the occupancy counter helper.
package demux_pkg;

  localparam int NCH    = 16;
  localparam int SEL_W  = 4;
  localparam int WIDTH  = 32;
  localparam int PEND_W = 5;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [PEND_W-1:0] pend_t;

  function automatic pend_t popcount_ch(input logic [NCH-1:0] v);
    pend_t cnt;
    cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      cnt = cnt + pend_t'(v[k]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a data register plus a valid flag.
// A load wins over a drain in the same cycle, so a full slot can be refilled with no bubble.
module demux_slot #(
  parameter int WIDTH = demux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux1t16_32_buf.sv
// Buffered 1-to-16 demultiplexer: each accepted word lands in the slot picked by s
// and waits there until that channel's consumer takes it.
module demux1t16_32_buf #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int NCH   = demux_pkg::NCH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [demux_pkg::SEL_W-1:0] s,
  input  logic [WIDTH-1:0]            i,
  input  logic                        i_valid,
  output logic                        i_ready,
  output logic [NCH*WIDTH-1:0]        o,
  output logic [NCH-1:0]              o_valid,
  input  logic [NCH-1:0]              o_ready,
  output logic [demux_pkg::PEND_W-1:0] pending
);

  import demux_pkg::*;

  logic           w_accept;
  logic [NCH-1:0] w_load;
  logic [NCH-1:0] w_drain;
  logic [NCH-1:0] w_next_valid;
  pend_t          r_pending;

  // Ready only looks at the selected slot, so it never depends on i_valid.
  assign i_ready  = ~o_valid[s] | o_ready[s];
  assign w_accept = i_valid & i_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign w_load[k] = w_accept & (s == sel_t'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_drain (o_ready[k]),
      .i_data  (i),
      .o_data  (o[k*WIDTH +: WIDTH]),
      .o_valid (o_valid[k])
    );
  end

  // Count the valid flags the slots are about to hold, so pending tracks o_valid exactly.
  assign w_drain      = o_valid & o_ready;
  assign w_next_valid = w_load | (o_valid & ~w_drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= popcount_ch(w_next_valid);
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_demux1t16_32_buf.sv
// Scoreboard bench for demux1t16_32_buf: each channel keeps a queue of words it owes
// the consumer; the monitor checks held data, valid flags and occupancy every cycle.
module tb_demux1t16_32_buf;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     s;
  logic [W-1:0]   i;
  logic           i_valid;
  logic           i_ready;
  logic [N*W-1:0] o;
  logic [N-1:0]   o_valid;
  logic [N-1:0]   o_ready;
  logic [4:0]     pending;

  demux1t16_32_buf #(.WIDTH(W), .NCH(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (s),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Words accepted but not yet consumed, oldest first, per channel.
  logic [W-1:0] expQ[N][$];
  int           pushCh = -1;
  bit           monEn  = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called just after a rising edge; drives one cycle of inputs and advances to the next edge.
  task automatic applyStimulus(input logic r, input logic [3:0] sel, input logic [W-1:0] d,
                               input logic v, input logic [N-1:0] ordy);
    logic expReady;
    pushCh  = -1;
    rst     = r;
    s       = sel;
    i       = d;
    i_valid = v;
    o_ready = ordy;
    expReady = (expQ[sel].size() == 0) || ordy[sel];
    #1;
    if (!r) checkOutput("i_ready", W'(i_ready), W'(expReady));
    if (!r && v && expReady) begin
      expQ[sel].push_back(d);
      pushCh = int'(sel);
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < N; k++) expQ[k].delete();
      pushCh = -1;
    end
  endtask

  logic [N-1:0] monExpValid;
  int           monTotal;
  int           monHeld;

  always @(negedge clk) begin
    if (monEn) begin
      monExpValid = '0;
      monTotal    = 0;
      for (int k = 0; k < N; k++) begin
        monHeld = expQ[k].size() - ((pushCh == k) ? 1 : 0);
        monExpValid[k] = (monHeld > 0);
        monTotal += monHeld;
        if (monHeld > 0) begin
          checkOutput($sformatf("ch%0d_data", k), o[k*W +: W], expQ[k][0]);
          if (o_ready[k]) void'(expQ[k].pop_front());
        end
      end
      checkOutput("o_valid", W'(o_valid), W'(monExpValid));
      checkOutput("pending", W'(pending), W'(monTotal));
    end
  end

  logic [N*W-1:0] rest;
  logic [3:0]     rs;
  logic [W-1:0]   rd;
  logic           rv;
  logic           rr;
  logic [N-1:0]   ro;
  bit             hold;
  int             leftover;

  initial begin
    rst = 1'b1; s = '0; i = '0; i_valid = 1'b0; o_ready = '0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 4'd0, '0, 1'b0, '0);
    applyStimulus(1'b1, 4'd0, '0, 1'b0, '0);
    monEn = 1'b1;

    // Reset state
    rst = 1'b0;
    #1;
    checkOutput("rst_o_valid", W'(o_valid), '0);
    checkOutput("rst_pending", W'(pending), '0);
    checkOutput("rst_o_zero", W'(o == '0), W'(1));
    checkOutput("rst_i_ready", W'(i_ready), W'(1));
    @(posedge clk);
    #1;

    // Single word to channel 3
    applyStimulus(1'b0, 4'd3, 32'hDEADBEEF, 1'b1, '0);
    checkOutput("s3_o_valid", W'(o_valid), 32'h0008);
    checkOutput("s3_data", o[127:96], 32'hDEADBEEF);
    checkOutput("s3_pending", W'(pending), W'(1));
    rest = o;
    rest[127:96] = '0;
    checkOutput("s3_others_zero", W'(rest == '0), W'(1));
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

    // Stall on a full channel, then drain and refill in the same cycle
    applyStimulus(1'b0, 4'd5, 32'h5555_0001, 1'b1, '0);
    applyStimulus(1'b0, 4'd5, 32'h5555_0002, 1'b1, '0);
    checkOutput("stall_hold", o[5*W +: W], 32'h5555_0001);
    applyStimulus(1'b0, 4'd5, 32'h5555_0002, 1'b1, 16'h0020);
    checkOutput("refill_data", o[5*W +: W], 32'h5555_0002);
    checkOutput("refill_valid", W'(o_valid), 32'h0020);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
    checkOutput("drain5_valid", W'(o_valid), '0);

    // Fill every channel, confirm full stall, then drain all at once
    for (int k = 0; k < N; k++) applyStimulus(1'b0, 4'(k), 32'h100 + k, 1'b1, '0);
    checkOutput("full_pending", W'(pending), W'(16));
    for (int k = 0; k < N; k++) checkOutput($sformatf("full_ch%0d", k), o[k*W +: W], 32'h100 + k);
    applyStimulus(1'b0, 4'd7, 32'hBAD0_0007, 1'b1, '0);
    checkOutput("full_no_load", o[7*W +: W], 32'h107);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
    checkOutput("empty_valid", W'(o_valid), '0);
    checkOutput("empty_pending", W'(pending), '0);

    // Accept on 2 while 9 drains
    applyStimulus(1'b0, 4'd9, 32'h9999_9999, 1'b1, '0);
    applyStimulus(1'b0, 4'd2, 32'h2222_2222, 1'b1, 16'h0200);
    checkOutput("swap_valid", W'(o_valid), 32'h0004);
    checkOutput("swap_pending", W'(pending), W'(1));
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

    // Reset mid-operation with a coinciding accept
    applyStimulus(1'b0, 4'd1, 32'h1111_1111, 1'b1, '0);
    applyStimulus(1'b0, 4'd7, 32'h7777_7777, 1'b1, '0);
    applyStimulus(1'b1, 4'd4, 32'h4444_4444, 1'b1, '0);
    checkOutput("mrst_valid", W'(o_valid), '0);
    checkOutput("mrst_pending", W'(pending), '0);
    checkOutput("mrst_o_zero", W'(o == '0), W'(1));

    // Random traffic; a refused offer is held stable until taken
    hold = 1'b0;
    rs = '0; rd = '0; rv = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!hold) begin
        rv = ($urandom_range(0, 99) < 60);
        rs = 4'($urandom);
        rd = $urandom;
      end
      ro = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rr = ($urandom_range(0, 999) == 0);
      applyStimulus(rr, rs, rd, rv, ro);
      hold = rv && !rr && (pushCh != int'(rs));
    end

    applyStimulus(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 4'd0, '0, 1'b0, '0);
    leftover = 0;
    for (int k = 0; k < N; k++) leftover += expQ[k].size();
    checkOutput("sb_empty", W'(leftover), '0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
